// File: rtl/sm_arbiter_if.sv
// sm_arbiter_if: shared-memory port bundle between the arbiter and the
// 4096x8 memory.
//   mem_en    - access strobe (arbiter -> memory)
//   mem_we    - write enable (arbiter -> memory)
//   mem_addr  - 12-bit address (arbiter -> memory)
//   mem_wdata - store data (arbiter -> memory)
//   mem_rdata - load data, valid while mem_ack is high (memory -> arbiter)
//   mem_ack   - completion (memory -> arbiter)
interface sm_arbiter_if;
  logic        mem_en;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/sm_arbiter.sv
// sm_arbiter: round-robin arbiter serialising N_CORES core load/store
// requests onto one shared-memory port, with a watchdog that aborts
// transactions the memory never acknowledges.
//   clk           - system clock, rising edge
//   reset         - asynchronous reset, active low
//   core_mem_req  - per-core request, held until its completion pulse
//   core_we       - per-core store(1)/load(0)
//   core_addr     - core i address at [12i+11:12i]
//   core_wdata    - core i store data at [8i+7:8i]
//   core_val_data - one-cycle completion pulse to the owner
//   core_rdata    - read data broadcast, valid with core_val_data
//   core_gnt      - one-hot owner of the memory port
//   mem_bus       - memory port (master side)
//   busy          - high whenever not IDLE
//   err_timeout   - sticky watchdog abort flag
//
// state  | meaning
// IDLE   | no owner; pick a round-robin winner if anyone requests
// ACCESS | mem_en high, waiting for mem_ack or watchdog expiry
// RESP   | completion pulse to the owner, release grant next edge
module sm_arbiter #(
  parameter int N_CORES = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_CORES-1:0]     core_mem_req,
  input  logic [N_CORES-1:0]     core_we,
  input  logic [12*N_CORES-1:0]  core_addr,
  input  logic [8*N_CORES-1:0]   core_wdata,
  output logic [N_CORES-1:0]     core_val_data,
  output logic [7:0]             core_rdata,
  output logic [N_CORES-1:0]     core_gnt,
  sm_arbiter_if.master           mem_bus,
  output logic                   busy,
  output logic                   err_timeout
);

  localparam int IW = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t               state, state_nxt;
  logic [IW-1:0]        last, last_nxt;
  logic [7:0]           wd_cnt, wd_cnt_nxt;
  logic [N_CORES-1:0]   gnt_nxt, val_nxt;
  logic [7:0]           rdata_nxt;
  logic                 err_nxt;
  logic                 en_q, en_nxt;
  logic                 we_q, we_nxt;
  logic [11:0]          addr_q, addr_nxt;
  logic [7:0]           wdata_q, wdata_nxt;

  logic [IW-1:0]        win;
  logic                 win_vld;

  logic [11:0]          addr_arr  [N_CORES];
  logic [7:0]           wdata_arr [N_CORES];

  for (genvar g = 0; g < N_CORES; g++) begin : g_unpack
    assign addr_arr[g]  = core_addr[12*g +: 12];
    assign wdata_arr[g] = core_wdata[8*g +: 8];
  end

  // Search starts one past the previous winner and wraps, so the previous
  // winner is considered last.
  always_comb begin : rr_pick
    int            idx;
    logic [IW-1:0] idx_w;
    win     = last;
    win_vld = 1'b0;
    for (int i = 1; i <= N_CORES; i++) begin
      idx   = (int'(last) + i) % N_CORES;
      idx_w = IW'(idx);
      if (!win_vld && core_mem_req[idx_w]) begin
        win     = idx_w;
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin : fsm_next
    state_nxt  = state;
    last_nxt   = last;
    wd_cnt_nxt = wd_cnt;
    gnt_nxt    = core_gnt;
    val_nxt    = '0;
    rdata_nxt  = core_rdata;
    err_nxt    = err_timeout;
    en_nxt     = en_q;
    we_nxt     = we_q;
    addr_nxt   = addr_q;
    wdata_nxt  = wdata_q;
    unique case (state)
      IDLE: begin
        if (win_vld) begin
          state_nxt    = ACCESS;
          last_nxt     = win;
          gnt_nxt      = '0;
          gnt_nxt[win] = 1'b1;
          en_nxt       = 1'b1;
          we_nxt       = core_we[win];
          addr_nxt     = addr_arr[win];
          wdata_nxt    = wdata_arr[win];
          wd_cnt_nxt   = '0;
        end
      end
      ACCESS: begin
        // An ack in the same cycle as watchdog expiry takes priority.
        if (mem_bus.mem_ack) begin
          if (!we_q) rdata_nxt = mem_bus.mem_rdata;
          en_nxt    = 1'b0;
          val_nxt   = core_gnt;
          state_nxt = RESP;
        end else begin
          wd_cnt_nxt = wd_cnt + 8'd1;
          if (wd_cnt + 8'd1 == TO_CNT) begin
            rdata_nxt = 8'hFF;
            err_nxt   = 1'b1;
            en_nxt    = 1'b0;
            val_nxt   = core_gnt;
            state_nxt = RESP;
          end
        end
      end
      RESP: begin
        gnt_nxt   = '0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      last          <= IW'(N_CORES - 1);
      wd_cnt        <= '0;
      core_gnt      <= '0;
      core_val_data <= '0;
      core_rdata    <= '0;
      err_timeout   <= 1'b0;
      en_q          <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
    end else begin
      state         <= state_nxt;
      last          <= last_nxt;
      wd_cnt        <= wd_cnt_nxt;
      core_gnt      <= gnt_nxt;
      core_val_data <= val_nxt;
      core_rdata    <= rdata_nxt;
      err_timeout   <= err_nxt;
      en_q          <= en_nxt;
      we_q          <= we_nxt;
      addr_q        <= addr_nxt;
      wdata_q       <= wdata_nxt;
    end
  end

  assign mem_bus.mem_en    = en_q;
  assign mem_bus.mem_we    = we_q;
  assign mem_bus.mem_addr  = addr_q;
  assign mem_bus.mem_wdata = wdata_q;
  assign busy              = (state != IDLE);

endmodule

// File: tb/tb_sm_arbiter.sv
// tb_sm_arbiter: directed self-checking bench for sm_arbiter (4 cores,
// TIMEOUT 15). Inputs change and outputs are sampled 1 time unit after
// each rising edge.
module tb_sm_arbiter;
  logic        clk;
  logic        reset;
  logic [3:0]  core_mem_req;
  logic [3:0]  core_we;
  logic [47:0] core_addr;
  logic [31:0] core_wdata;
  logic [3:0]  core_val_data;
  logic [7:0]  core_rdata;
  logic [3:0]  core_gnt;
  logic        busy;
  logic        err_timeout;

  int checks   = 0;
  int failures = 0;

  sm_arbiter_if mem_bus();

  sm_arbiter #(.N_CORES(4), .TIMEOUT(15)) dut (
    .clk           (clk),
    .reset         (reset),
    .core_mem_req  (core_mem_req),
    .core_we       (core_we),
    .core_addr     (core_addr),
    .core_wdata    (core_wdata),
    .core_val_data (core_val_data),
    .core_rdata    (core_rdata),
    .core_gnt      (core_gnt),
    .mem_bus       (mem_bus.master),
    .busy          (busy),
    .err_timeout   (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset        = 1'b0;
    core_mem_req = '0;
    core_we      = '0;
    core_addr    = '0;
    core_wdata   = '0;
    mem_bus.mem_ack   = 1'b0;
    mem_bus.mem_rdata = '0;
    #2;
    checks++; if ({core_gnt, core_val_data} !== 8'h00) begin failures++; $display("FAIL reset_gnt_val got=%h exp=00", {core_gnt, core_val_data}); end
    checks++; if (core_rdata !== 8'h00) begin failures++; $display("FAIL reset_rdata got=%h exp=00", core_rdata); end
    checks++; if ({mem_bus.mem_en, mem_bus.mem_we, busy, err_timeout} !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {mem_bus.mem_en, mem_bus.mem_we, busy, err_timeout}); end
    checks++; if ({mem_bus.mem_addr, mem_bus.mem_wdata} !== 20'h0) begin failures++; $display("FAIL reset_addr_wdata got=%h exp=00000", {mem_bus.mem_addr, mem_bus.mem_wdata}); end
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_single_load();
    core_mem_req         = 4'b0100;
    core_we              = 4'b0000;
    core_addr[24 +: 12]  = 12'h0A5;
    step();
    checks++; if (mem_bus.mem_en !== 1'b1 || mem_bus.mem_we !== 1'b0 || mem_bus.mem_addr !== 12'h0A5) begin failures++; $display("FAIL load_access got en=%b we=%b addr=%h exp en=1 we=0 addr=0a5", mem_bus.mem_en, mem_bus.mem_we, mem_bus.mem_addr); end
    checks++; if (core_gnt !== 4'b0100 || busy !== 1'b1) begin failures++; $display("FAIL load_gnt got gnt=%b busy=%b exp gnt=0100 busy=1", core_gnt, busy); end
    mem_bus.mem_ack   = 1'b1;
    mem_bus.mem_rdata = 8'h3C;
    step();
    checks++; if (core_val_data !== 4'b0100 || core_rdata !== 8'h3C) begin failures++; $display("FAIL load_resp got val=%b rdata=%h exp val=0100 rdata=3c", core_val_data, core_rdata); end
    checks++; if (mem_bus.mem_en !== 1'b0) begin failures++; $display("FAIL load_en_one_cycle got=%b exp=0", mem_bus.mem_en); end
    core_mem_req    = '0;
    mem_bus.mem_ack = 1'b0;
    step();
    checks++; if (core_val_data !== 4'b0000 || core_gnt !== 4'b0000 || busy !== 1'b0) begin failures++; $display("FAIL load_idle got val=%b gnt=%b busy=%b exp 0000 0000 0", core_val_data, core_gnt, busy); end
  endtask

  task automatic test_store();
    core_mem_req        = 4'b0001;
    core_we             = 4'b0001;
    core_addr[0 +: 12]  = 12'hFFF;
    core_wdata[0 +: 8]  = 8'h77;
    step();
    checks++; if (mem_bus.mem_we !== 1'b1 || mem_bus.mem_wdata !== 8'h77 || mem_bus.mem_addr !== 12'hFFF) begin failures++; $display("FAIL store_access got we=%b wdata=%h addr=%h exp we=1 wdata=77 addr=fff", mem_bus.mem_we, mem_bus.mem_wdata, mem_bus.mem_addr); end
    checks++; if (core_gnt !== 4'b0001) begin failures++; $display("FAIL store_gnt got=%b exp=0001", core_gnt); end
    mem_bus.mem_ack   = 1'b1;
    mem_bus.mem_rdata = 8'hAA;
    step();
    checks++; if (core_val_data !== 4'b0001 || core_rdata !== 8'h3C) begin failures++; $display("FAIL store_resp got val=%b rdata=%h exp val=0001 rdata=3c", core_val_data, core_rdata); end
    core_mem_req    = '0;
    core_we         = '0;
    mem_bus.mem_ack = 1'b0;
    step();
  endtask

  task automatic test_contention();
    logic [3:0] exp_oh;
    apply_reset();
    for (int i = 0; i < 4; i++) core_addr[12*i +: 12] = 12'h100 + 12'(i);
    core_we           = '0;
    core_mem_req      = 4'b1111;
    mem_bus.mem_ack   = 1'b1;
    mem_bus.mem_rdata = 8'h55;
    for (int n = 0; n < 6; n++) begin
      exp_oh = 4'b0001 << (n % 4);
      step();
      checks++; if (core_gnt !== exp_oh || mem_bus.mem_addr !== 12'h100 + 12'(n % 4)) begin failures++; $display("FAIL rr_grant%0d got gnt=%b addr=%h exp gnt=%b addr=%h", n, core_gnt, mem_bus.mem_addr, exp_oh, 12'h100 + 12'(n % 4)); end
      step();
      checks++; if (core_val_data !== exp_oh) begin failures++; $display("FAIL rr_val%0d got=%b exp=%b", n, core_val_data, exp_oh); end
      if (n == 5) core_mem_req = '0;
      step();
      checks++; if (core_val_data !== 4'b0000 || core_gnt !== 4'b0000) begin failures++; $display("FAIL rr_pulse_end%0d got val=%b gnt=%b exp 0000 0000", n, core_val_data, core_gnt); end
    end
    mem_bus.mem_ack = 1'b0;
  endtask

  task automatic test_mem_wait();
    core_mem_req        = 4'b0010;
    core_we             = 4'b0000;
    core_addr[12 +: 12] = 12'h321;
    for (int k = 0; k < 6; k++) begin
      step();
      checks++; if (mem_bus.mem_en !== 1'b1 || mem_bus.mem_addr !== 12'h321 || mem_bus.mem_we !== 1'b0 || core_val_data !== 4'b0000) begin failures++; $display("FAIL wait_stable%0d got en=%b addr=%h we=%b val=%b exp 1 321 0 0000", k, mem_bus.mem_en, mem_bus.mem_addr, mem_bus.mem_we, core_val_data); end
    end
    mem_bus.mem_ack   = 1'b1;
    mem_bus.mem_rdata = 8'h5A;
    step();
    checks++; if (core_val_data !== 4'b0010 || core_rdata !== 8'h5A || mem_bus.mem_en !== 1'b0) begin failures++; $display("FAIL wait_resp got val=%b rdata=%h en=%b exp 0010 5a 0", core_val_data, core_rdata, mem_bus.mem_en); end
    core_mem_req    = '0;
    mem_bus.mem_ack = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    int en_cycles;
    core_mem_req        = 4'b1000;
    core_we             = 4'b0000;
    core_addr[36 +: 12] = 12'h7E0;
    en_cycles = 0;
    for (int k = 0; k < 15; k++) begin
      step();
      if (mem_bus.mem_en === 1'b1) en_cycles++;
    end
    checks++; if (en_cycles != 15 || err_timeout !== 1'b0) begin failures++; $display("FAIL to_en_cycles got en=%0d err=%b exp en=15 err=0", en_cycles, err_timeout); end
    step();
    checks++; if (mem_bus.mem_en !== 1'b0 || core_val_data !== 4'b1000 || core_rdata !== 8'hFF || err_timeout !== 1'b1) begin failures++; $display("FAIL to_abort got en=%b val=%b rdata=%h err=%b exp 0 1000 ff 1", mem_bus.mem_en, core_val_data, core_rdata, err_timeout); end
    core_mem_req = '0;
    step();
    core_mem_req       = 4'b0001;
    core_addr[0 +: 12] = 12'h010;
    step();
    mem_bus.mem_ack   = 1'b1;
    mem_bus.mem_rdata = 8'h11;
    step();
    checks++; if (core_val_data !== 4'b0001 || core_rdata !== 8'h11 || err_timeout !== 1'b1) begin failures++; $display("FAIL to_sticky got val=%b rdata=%h err=%b exp 0001 11 1", core_val_data, core_rdata, err_timeout); end
    core_mem_req    = '0;
    mem_bus.mem_ack = 1'b0;
    step();
  endtask

  task automatic test_ack_at_timeout();
    apply_reset();
    core_mem_req        = 4'b0100;
    core_we             = 4'b0000;
    core_addr[24 +: 12] = 12'h222;
    for (int k = 0; k < 15; k++) step();
    checks++; if (mem_bus.mem_en !== 1'b1) begin failures++; $display("FAIL ackto_en got=%b exp=1", mem_bus.mem_en); end
    mem_bus.mem_ack   = 1'b1;
    mem_bus.mem_rdata = 8'h42;
    step();
    checks++; if (core_val_data !== 4'b0100 || core_rdata !== 8'h42 || err_timeout !== 1'b0) begin failures++; $display("FAIL ackto_resp got val=%b rdata=%h err=%b exp 0100 42 0", core_val_data, core_rdata, err_timeout); end
    core_mem_req    = '0;
    mem_bus.mem_ack = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_access();
    core_mem_req        = 4'b0010;
    core_we             = 4'b0010;
    core_addr[12 +: 12] = 12'h456;
    core_wdata[8 +: 8]  = 8'h9C;
    step();
    checks++; if (busy !== 1'b1 || mem_bus.mem_en !== 1'b1 || mem_bus.mem_wdata !== 8'h9C) begin failures++; $display("FAIL rst_pre got busy=%b en=%b wdata=%h exp 1 1 9c", busy, mem_bus.mem_en, mem_bus.mem_wdata); end
    #3;
    reset = 1'b0;
    #1;
    checks++; if ({busy, err_timeout, mem_bus.mem_en, mem_bus.mem_we} !== 4'b0000 || core_gnt !== 4'b0000 || core_val_data !== 4'b0000) begin failures++; $display("FAIL rst_mid_flags got busy=%b err=%b en=%b we=%b gnt=%b val=%b exp all 0", busy, err_timeout, mem_bus.mem_en, mem_bus.mem_we, core_gnt, core_val_data); end
    checks++; if (mem_bus.mem_addr !== 12'h000 || mem_bus.mem_wdata !== 8'h00 || core_rdata !== 8'h00) begin failures++; $display("FAIL rst_mid_data got addr=%h wdata=%h rdata=%h exp 000 00 00", mem_bus.mem_addr, mem_bus.mem_wdata, core_rdata); end
    core_mem_req = 4'b0011;
    core_we      = 4'b0000;
    #2;
    reset = 1'b1;
    step();
    checks++; if (core_gnt !== 4'b0001) begin failures++; $display("FAIL rst_first_grant got=%b exp=0001", core_gnt); end
    core_mem_req = '0;
    mem_bus.mem_ack = 1'b1;
    step();
    mem_bus.mem_ack = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=expired exp=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    test_reset();
    test_single_load();
    test_store();
    test_contention();
    test_mem_wait();
    test_timeout();
    test_ack_at_timeout();
    test_reset_mid_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
